// File: rtl/wb_io_debug_port.sv
// Wishbone classic IO slave for POST port 0x80 and the 0xE9 debug console with a byte FIFO.
// Optional build macro WB_IO_DBG_STALL_EN: pushes to a full FIFO wait for space instead of dropping.
module wb_io_debug_port #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned AW         = 16
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_n_i,
    input  logic [AW-1:0] wb_adr_i,
    input  logic [31:0]   wb_dat_i,
    input  logic [3:0]    wb_sel_i,
    input  logic          wb_we_i,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic [2:0]    wb_cti_i,
    input  logic [1:0]    wb_bte_i,
    output logic [31:0]   wb_dat_o,
    output logic          wb_ack_o,
    output logic          wb_err_o,
    output logic          wb_rty_o,
    output logic [7:0]    post_code_o,
    output logic          post_stb_o,
    output logic [7:0]    con_data_o,
    output logic          con_valid_o,
    input  logic          con_ready_i
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned IDX_W = AW - 2;
    localparam logic [IDX_W-1:0] POST_IDX = IDX_W'(32'h80 >> 2);
    localparam logic [IDX_W-1:0] CON_IDX  = IDX_W'(32'hE8 >> 2);

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             ovf;

    logic        req;
    logic        hit_post;
    logic        hit_con;
    logic        mapped;
    logic        wr;
    logic        post_wr;
    logic        push_req;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    logic        blocked;
    logic        stall;
    logic        ovf_set;
    logic        ovf_clr;
    logic        commit;
    logic [7:0]  cnt_sat;
    logic [31:0] rdata;
    logic        unused_ok;

    assign unused_ok = ^{wb_cti_i, wb_bte_i, wb_adr_i[1:0], wb_dat_i[31:24], wb_dat_i[22:16]};

    assign wb_rty_o    = 1'b0;
    assign con_data_o  = mem[rd_ptr];
    assign con_valid_o = ~empty;

    // Request decode: a new access is seen only while no termination is showing
    assign req      = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
    assign hit_post = (wb_adr_i[AW-1:2] == POST_IDX);
    assign hit_con  = (wb_adr_i[AW-1:2] == CON_IDX);
    assign mapped   = hit_post | hit_con;
    assign wr       = req & wb_we_i;

    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign pop      = ~empty & con_ready_i;
    assign push_req = wr & hit_con & wb_sel_i[1];
    assign blocked  = push_req & full & ~pop;

`ifdef WB_IO_DBG_STALL_EN
    assign stall   = blocked;
    assign ovf_set = 1'b0;
`else
    assign stall   = 1'b0;
    assign ovf_set = blocked;
`endif

    assign commit  = req & mapped & ~stall;
    assign push    = push_req & ~blocked;
    assign post_wr = wr & hit_post & wb_sel_i[0];
    assign ovf_clr = wr & hit_con & wb_sel_i[2] & wb_dat_i[23] & ~stall;

    assign cnt_sat = (32'(count) > 32'd255) ? 8'hFF : 8'(count);

    // Read mux, pre-update values, unselected lanes forced to zero
    always_comb begin
        rdata = '0;
        if (hit_post) begin
            rdata[7:0] = post_code_o;
        end
        if (hit_con) begin
            rdata[15:8]  = 8'hE9;
            rdata[23:16] = {ovf, 5'b0, full, empty};
            rdata[31:24] = cnt_sat;
        end
        for (int i = 0; i < 4; i++) begin
            if (!wb_sel_i[i]) begin
                rdata[i*8 +: 8] = 8'h00;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            wb_ack_o    <= 1'b0;
            wb_err_o    <= 1'b0;
            wb_dat_o    <= '0;
            post_code_o <= '0;
            post_stb_o  <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            ovf         <= 1'b0;
        end else begin
            wb_ack_o   <= commit;
            wb_err_o   <= req & ~mapped;
            wb_dat_o   <= (commit & ~wb_we_i) ? rdata : '0;
            post_stb_o <= post_wr;
            if (post_wr) begin
                post_code_o <= wb_dat_i[7:0];
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
            ovf   <= (ovf & ~ovf_clr) | ovf_set;
        end
    end

    // Storage needs no reset; occupancy is tracked by count
    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            mem[wr_ptr] <= wb_dat_i[15:8];
        end
    end

endmodule

// File: tb/tb_wb_io_debug_port.sv
// Directed self-checking bench for wb_io_debug_port (POST port, console FIFO, errors, reset).
module tb_wb_io_debug_port;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] adr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic [31:0] dat_o;
    logic        ack;
    logic        err;
    logic        rty;
    logic [7:0]  post_code;
    logic        post_stb;
    logic [7:0]  con_data;
    logic        con_valid;
    logic        con_ready;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wb_io_debug_port #(.FIFO_DEPTH(16), .AW(16)) dut (
        .wb_clk_i    (clk),
        .wb_rst_n_i  (rst_n),
        .wb_adr_i    (adr),
        .wb_dat_i    (wdat),
        .wb_sel_i    (sel),
        .wb_we_i     (we),
        .wb_cyc_i    (cyc),
        .wb_stb_i    (stb),
        .wb_cti_i    (3'b000),
        .wb_bte_i    (2'b00),
        .wb_dat_o    (dat_o),
        .wb_ack_o    (ack),
        .wb_err_o    (err),
        .wb_rty_o    (rty),
        .post_code_o (post_code),
        .post_stb_o  (post_stb),
        .con_data_o  (con_data),
        .con_valid_o (con_valid),
        .con_ready_i (con_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One access; returns at posedge+1 of the terminating cycle, bounded at 20 cycles
    task automatic wb_xfer(input logic [15:0] a, input logic [3:0] s, input logic w,
                           input logic [31:0] d, output logic [31:0] rd,
                           output logic k, output logic e, output int n);
        if (ack || err) begin
            @(posedge clk); #1;
        end
        adr = a; sel = s; we = w; wdat = d; cyc = 1'b1; stb = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(ack || err) && n < 20);
        rd = dat_o; k = ack; e = err;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'b0;
    endtask

    task automatic wb_wr(input string tag, input logic [15:0] a, input logic [3:0] s,
                         input logic [31:0] d);
        logic [31:0] rd;
        logic k, e;
        int n;
        wb_xfer(a, s, 1'b1, d, rd, k, e, n);
        check({tag, "_ack"}, 32'(k), 32'd1);
        check({tag, "_lat"}, 32'(n), 32'd1);
    endtask

    task automatic wb_rd(input string tag, input logic [15:0] a, input logic [3:0] s,
                         input logic [31:0] exp);
        logic [31:0] rd;
        logic k, e;
        int n;
        wb_xfer(a, s, 1'b0, 32'h0, rd, k, e, n);
        check({tag, "_ack"}, 32'(k), 32'd1);
        check({tag, "_dat"}, rd, exp);
    endtask

    initial begin
        logic [31:0] rd;
        logic        k, e;
        int          n;
        logic [7:0]  first;

        rst_n = 1'b0; adr = '0; wdat = '0; sel = '0; we = 1'b0;
        cyc = 1'b0; stb = 1'b0; con_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_dat", dat_o, 32'h0);
        check("rst_post", 32'(post_code), 32'h0);
        check("rst_valid", 32'(con_valid), 32'd0);
        check("rst_rty", 32'(rty), 32'd0);
        rst_n = 1'b1;

        // T1: POST write
        wb_wr("t1_post", 16'h0080, 4'b0001, 32'h0000_0055);
        check("t1_code", 32'(post_code), 32'h55);
        check("t1_stb_hi", 32'(post_stb), 32'd1);
        @(posedge clk); #1;
        check("t1_stb_lo", 32'(post_stb), 32'd0);
        check("t1_ack_lo", 32'(ack), 32'd0);
        wb_rd("t1_rd", 16'h0080, 4'b1111, 32'h0000_0055);

        // T2: "Hi" through the console with the sink ready
        con_ready = 1'b1;
        wb_wr("t2_h", 16'h00E8, 4'b0010, 32'h0000_4800);
        check("t2_head_h", 32'(con_data), 32'h48);
        check("t2_valid_h", 32'(con_valid), 32'd1);
        wb_wr("t2_i", 16'h00E8, 4'b0010, 32'h0000_6900);
        check("t2_head_i", 32'(con_data), 32'h69);
        @(posedge clk); #1;
        check("t2_empty", 32'(con_valid), 32'd0);
        con_ready = 1'b0;
        wb_rd("t2_stat", 16'h00E8, 4'b1100, 32'h0001_0000);

        // T3: overfill with the sink stalled
        for (int i = 0; i < 16; i++) begin
            wb_wr("t3_push", 16'h00E8, 4'b0010, {16'h0, 8'(8'hA0 + i), 8'h00});
        end
        wb_rd("t3_full", 16'h00E8, 4'b1100, 32'h1002_0000);
`ifdef WB_IO_DBG_STALL_EN
        @(posedge clk); #1;
        fork
            wb_xfer(16'h00E8, 4'b0010, 1'b1, 32'h0000_B000, rd, k, e, n);
            begin
                repeat (4) begin
                    @(posedge clk); #1;
                end
                con_ready = 1'b1;
                @(posedge clk); #1;
                con_ready = 1'b0;
            end
        join
        check("t3_stall_ack", 32'(k), 32'd1);
        check("t3_stall_lat", 32'(n), 32'd5);
        wb_rd("t3_stat", 16'h00E8, 4'b0100, 32'h0002_0000);
        first = 8'hA1;
`else
        wb_xfer(16'h00E8, 4'b0010, 1'b1, 32'h0000_B000, rd, k, e, n);
        check("t3_ovf_ack", 32'(k), 32'd1);
        check("t3_ovf_lat", 32'(n), 32'd1);
        wb_rd("t3_stat", 16'h00E8, 4'b0100, 32'h0082_0000);
        first = 8'hA0;
`endif
        wb_rd("t3_cnt", 16'h00E8, 4'b1000, 32'h1000_0000);
        con_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("t3_drain", 32'(con_data), 32'(8'(first + 8'(i))));
            @(posedge clk); #1;
        end
        con_ready = 1'b0;
        check("t3_drained", 32'(con_valid), 32'd0);
        wb_wr("t3_clr", 16'h00E8, 4'b0100, 32'h0080_0000);
        wb_rd("t3_stat2", 16'h00E8, 4'b0100, 32'h0001_0000);

        // T4: status after three pushes, lane masking, multi-lane write, sel=0
        wb_wr("t4_push", 16'h00E8, 4'b0010, 32'h0000_3100);
        wb_wr("t4_push", 16'h00E8, 4'b0010, 32'h0000_3200);
        wb_wr("t4_push", 16'h00E8, 4'b0010, 32'h0000_3300);
        wb_rd("t4_stat", 16'h00E8, 4'b1110, 32'h0300_E900);
        wb_rd("t4_lane0", 16'h00E8, 4'b0001, 32'h0000_0000);
        wb_rd("t4_probe", 16'h00E8, 4'b0010, 32'h0000_E900);
        wb_wr("t4_multi", 16'h00E8, 4'b0110, 32'h0080_4100);
        wb_rd("t4_cnt", 16'h00E8, 4'b1000, 32'h0400_0000);
        check("t4_head", 32'(con_data), 32'h31);
        wb_wr("t4_sel0", 16'h0080, 4'b0000, 32'h0000_0077);
        check("t4_sel0_code", 32'(post_code), 32'h55);
        check("t4_sel0_stb", 32'(post_stb), 32'd0);
        wb_rd("t4_sel0_rd", 16'h0080, 4'b0000, 32'h0);
        wb_wr("t4_lane1_post", 16'h0080, 4'b0010, 32'h0000_9900);
        check("t4_lane1_code", 32'(post_code), 32'h55);
        con_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        con_ready = 1'b0;
        check("t4_drained", 32'(con_valid), 32'd0);

        // T5: unmapped dword terminates with error
        wb_xfer(16'h0060, 4'b1111, 1'b0, 32'h0, rd, k, e, n);
        check("t5_err", 32'(e), 32'd1);
        check("t5_ack", 32'(k), 32'd0);
        check("t5_lat", 32'(n), 32'd1);
        @(posedge clk); #1;
        check("t5_err_lo", 32'(err), 32'd0);
        check("t5_code", 32'(post_code), 32'h55);
        check("t5_valid", 32'(con_valid), 32'd0);

        // T6: reset while a write is pending
        wb_wr("t6_push", 16'h00E8, 4'b0010, 32'h0000_5A00);
        check("t6_valid", 32'(con_valid), 32'd1);
        adr = 16'h0080; sel = 4'b0001; we = 1'b1; wdat = 32'h0000_0011;
        cyc = 1'b1; stb = 1'b1; rst_n = 1'b0;
        @(posedge clk); #1;
        check("t6_rst_ack", 32'(ack), 32'd0);
        check("t6_rst_code", 32'(post_code), 32'h0);
        check("t6_rst_valid", 32'(con_valid), 32'd0);
        @(posedge clk); #1;
        check("t6_rst_ack2", 32'(ack), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("t6_retry_ack", 32'(ack), 32'd1);
        check("t6_retry_code", 32'(post_code), 32'h11);
        check("t6_retry_stb", 32'(post_stb), 32'd1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'b0;
        @(posedge clk); #1;
        check("t6_ack_lo", 32'(ack), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
